// File: rtl/store_pkg.sv
// store_pkg: default store_counter constants and level-width helper
package store_pkg;
  localparam int STORE_CNT_W = 8;
  localparam int STORE_DEPTH = 4;
  localparam bit STORE_WRAP = 1'b1;
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: FWFT buffer (newclk_k,rst,wr_en,wr_data,rd_ready -> rd_valid,rd_data,level,full); wr_en must not be raised when full without a pop
module capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             newclk_k,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign do_pop = rd_ready && rd_valid;
  assign rd_valid = level != '0;
  assign full = level == LW'(DEPTH);
  assign rd_data = rd_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge newclk_k) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
  always_ff @(posedge newclk_k) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(wr_en) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/store_counter.sv
// store_counter: event counter with capture FIFO (newclk_k,rst,cnt_en,clr,cap_req,rd_ready -> rd_valid,rd_data,count,level,ovf_flag,drop_flag)
module store_counter
  import store_pkg::*;
#(
  parameter int CNT_W = STORE_CNT_W,
  parameter int DEPTH = STORE_DEPTH,
  parameter bit WRAP = STORE_WRAP,
  localparam int LW = lvl_w(DEPTH)
) (
  input  logic             newclk_k,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             clr,
  input  logic             cap_req,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic [LW-1:0]    level,
  output logic             ovf_flag,
  output logic             drop_flag
);
  logic full, drop_ev, wr_en, at_max;
  assign at_max = count == '1;
  assign drop_ev = cap_req && full && !rd_ready;
  assign wr_en = cap_req && !drop_ev;
  capture_fifo #(.WIDTH(CNT_W), .DEPTH(DEPTH)) u_fifo (
    .newclk_k(newclk_k),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(count),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .level(level),
    .full(full)
  );
  always_ff @(posedge newclk_k) begin
    if (rst) begin
      count <= '0;
      ovf_flag <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      count <= clr ? '0 : (cnt_en && (WRAP || !at_max)) ? count + 1'b1 : count;
      ovf_flag <= !clr && (ovf_flag || (cnt_en && at_max));
      drop_flag <= !clr && (drop_flag || drop_ev);
    end
  end
endmodule

// File: tb/tb_store_counter.sv
// tb_store_counter: queue-model checking of store_counter, wrap and saturate instances
module tb_store_counter;
  logic newclk_k = 1'b0;
  logic rst = 1'b1, cnt_en = 1'b0, clr = 1'b0, cap_req = 1'b0, rd_ready = 1'b0;
  logic rd_valid, ovf_flag, drop_flag;
  logic [7:0] rd_data, count;
  logic [2:0] level;
  logic rd_valid_s, ovf_s, drop_s;
  logic [7:0] rd_data_s, count_s;
  logic [2:0] level_s;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_sat = 0;
  bit m_ovf = 0, m_ovf_s = 0, m_drop = 0;
  int q[$];
  always #5 newclk_k = ~newclk_k;
  store_counter dut (
    .newclk_k(newclk_k), .rst(rst), .cnt_en(cnt_en), .clr(clr), .cap_req(cap_req),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .level(level), .ovf_flag(ovf_flag), .drop_flag(drop_flag)
  );
  store_counter #(.WRAP(1'b0)) dut_s (
    .newclk_k(newclk_k), .rst(rst), .cnt_en(cnt_en), .clr(clr), .cap_req(cap_req),
    .rd_ready(rd_ready), .rd_valid(rd_valid_s), .rd_data(rd_data_s), .count(count_s),
    .level(level_s), .ovf_flag(ovf_s), .drop_flag(drop_s)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model();
    bit pop, drop_ev, ovf_ev, sat_ev;
    if (rst) begin
      m_cnt = 0; m_sat = 0; m_ovf = 0; m_ovf_s = 0; m_drop = 0;
      q.delete();
    end else begin
      pop = q.size() > 0 && rd_ready;
      drop_ev = cap_req && q.size() == 4 && !pop;
      if (pop) void'(q.pop_front());
      if (cap_req && !drop_ev) q.push_back(m_cnt);
      ovf_ev = cnt_en && m_cnt == 255;
      sat_ev = cnt_en && m_sat == 255;
      m_cnt = clr ? 0 : cnt_en ? (m_cnt + 1) % 256 : m_cnt;
      m_sat = clr ? 0 : (cnt_en && m_sat < 255) ? m_sat + 1 : m_sat;
      m_ovf = !clr && (m_ovf || ovf_ev);
      m_ovf_s = !clr && (m_ovf_s || sat_ev);
      m_drop = !clr && (m_drop || drop_ev);
    end
  endtask
  task automatic step();
    @(posedge newclk_k);
    @(negedge newclk_k);
    model();
    chk("count", count, m_cnt);
    chk("level", level, q.size());
    chk("rd_valid", rd_valid, q.size() > 0);
    if (q.size() > 0) chk("rd_data", rd_data, q[0]);
    chk("ovf_flag", ovf_flag, m_ovf);
    chk("drop_flag", drop_flag, m_drop);
    chk("sat_count", count_s, m_sat);
    chk("sat_ovf", ovf_s, m_ovf_s);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  initial begin
    step();
    rst = 0;
    chk("lit_rst_count", count, 0);
    chk("lit_rst_level", level, 0);
    chk("lit_rst_valid", rd_valid, 0);
    chk("lit_rst_data", rd_data, 0);
    chk("lit_rst_ovf", ovf_flag, 0);
    chk("lit_rst_drop", drop_flag, 0);
    cnt_en = 1; run(5); cnt_en = 0;
    cap_req = 1; step(); cap_req = 0;
    chk("lit_cap_valid", rd_valid, 1);
    chk("lit_cap_data", rd_data, 5);
    chk("lit_cap_level", level, 1);
    chk("lit_cap_ovf", ovf_flag, 0);
    rd_ready = 1; step(); rd_ready = 0;
    clr = 1; step(); clr = 0;
    cnt_en = 1; run(254);
    chk("lit_254", count, 254);
    run(3); cnt_en = 0;
    chk("lit_wrap_count", count, 1);
    chk("lit_wrap_ovf", ovf_flag, 1);
    chk("lit_sat_count", count_s, 255);
    chk("lit_sat_ovf", ovf_s, 1);
    clr = 1; step(); clr = 0;
    chk("lit_clr_ovf", ovf_flag, 0);
    cnt_en = 1; run(10);
    cap_req = 1; run(6); cap_req = 0; cnt_en = 0;
    chk("lit_full_level", level, 4);
    chk("lit_full_drop", drop_flag, 1);
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("lit_drain_data", rd_data, 10 + i);
      step();
    end
    rd_ready = 0;
    chk("lit_drain_empty", rd_valid, 0);
    clr = 1; step(); clr = 0;
    cnt_en = 1; run(10);
    cap_req = 1; run(4); cap_req = 0;
    run(6); cnt_en = 0;
    chk("lit_pp_count", count, 20);
    chk("lit_pp_head", rd_data, 10);
    cap_req = 1; rd_ready = 1; step(); cap_req = 0;
    chk("lit_pp_level", level, 4);
    chk("lit_pp_drop", drop_flag, 0);
    chk("lit_pp_next", rd_data, 11);
    run(3);
    chk("lit_pp_newest", rd_data, 20);
    step(); rd_ready = 0;
    clr = 1; step(); clr = 0;
    cnt_en = 1; run(7); cnt_en = 0;
    cap_req = 1; clr = 1; step(); cap_req = 0; clr = 0;
    chk("lit_cc_data", rd_data, 7);
    chk("lit_cc_count", count, 0);
    chk("lit_cc_ovf", ovf_flag, 0);
    rd_ready = 1; step(); rd_ready = 0;
    clr = 1; step(); clr = 0;
    cnt_en = 1; run(256); cnt_en = 0;
    cap_req = 1; run(3); cap_req = 0;
    chk("lit_pre_rst_level", level, 3);
    chk("lit_pre_rst_ovf", ovf_flag, 1);
    rst = 1; step(); rst = 0;
    chk("lit_mid_rst_level", level, 0);
    chk("lit_mid_rst_valid", rd_valid, 0);
    chk("lit_mid_rst_count", count, 0);
    chk("lit_mid_rst_ovf", ovf_flag, 0);
    chk("lit_mid_rst_sat", count_s, 0);
    run(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
